// File: rtl/fp_pkg.sv
// Shared types and helpers for the sequential floating-point add/subtract unit.
package fp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORMAL,
    CLS_INF,
    CLS_NAN
  } fp_class_t;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  localparam int NAN_MAX_W = 128;

  // Quiet NaN {0, all-ones, 1, 0...}; callers cast down to their own width.
  function automatic logic [NAN_MAX_W-1:0] canonical_nan(input int exp_w, input int man_w);
    logic [NAN_MAX_W-1:0] ones;
    ones = (NAN_MAX_W'(1) << (exp_w + 1)) - NAN_MAX_W'(1);
    return ones << (man_w - 1);
  endfunction

  // Subnormals classify as zero so they are flushed.
  function automatic fp_class_t classify(input logic exp_zero, input logic exp_ones,
                                         input logic man_zero);
    if (exp_zero) return CLS_ZERO;
    if (exp_ones) return man_zero ? CLS_INF : CLS_NAN;
    return CLS_NORMAL;
  endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Right barrel shifter whose LSB collects the OR of every bit shifted past it.
module fp_align_shifter #(
  parameter int WIDTH = 27,
  parameter int SHW   = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic [SHW-1:0]   amount,
  output logic [WIDTH-1:0] shifted
);

  logic [WIDTH-1:0] plain;
  logic [WIDTH-1:0] lost_mask;
  logic             sticky;

  always_comb begin
    plain     = value >> amount;
    lost_mask = ~({WIDTH{1'b1}} << amount);
    sticky    = |(value & lost_mask);
    shifted   = {plain[WIDTH-1:1], plain[0] | sticky};
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754-style adder/subtractor: align, add, iterative normalise, round.
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic [3:0]   flags
);

  // Working significand: hidden, mantissa, guard, round, sticky.
  localparam int SW = MAN_W + 4;
  localparam logic [W-1:0] QNAN = W'(canonical_nan(EXP_W, MAN_W));
  localparam logic [3:0] F_INVALID = 4'(1) << FLAG_INVALID;
  localparam logic [3:0] F_OVFL    = 4'(1) << FLAG_OVERFLOW;
  localparam logic [3:0] F_UFLOW   = 4'(1) << FLAG_UNDERFLOW;
  localparam logic [3:0] F_INEXACT = 4'(1) << FLAG_INEXACT;
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  state_t state, next_state;

  logic [W-1:0]   a_r, b_r;
  logic           op_r;
  logic           sign_r, eff_sub_r;
  logic [EXP_W:0] exp_r;
  logic [SW-1:0]  sig_r, sigb_r;
  logic [W-1:0]   out_r;
  logic [3:0]     flags_r;

  logic             s1, s2;
  logic [EXP_W-1:0] e1, e2, e_big, e_small, e_diff;
  logic [MAN_W-1:0] m1, m2, m_big, m_small;
  fp_class_t        cls1, cls2;
  logic             swap, s_big, special;
  logic [W-1:0]     spec_out;
  logic [3:0]       spec_flags;
  logic [SW-1:0]    sigb_aligned;

  always_comb begin
    s1      = a_r[W-1];
    e1      = a_r[W-2:MAN_W];
    m1      = a_r[MAN_W-1:0];
    s2      = b_r[W-1] ^ op_r;
    e2      = b_r[W-2:MAN_W];
    m2      = b_r[MAN_W-1:0];
    cls1    = classify(e1 == '0, &e1, m1 == '0);
    cls2    = classify(e2 == '0, &e2, m2 == '0);
    swap    = {e2, m2} > {e1, m1};
    s_big   = swap ? s2 : s1;
    e_big   = swap ? e2 : e1;
    e_small = swap ? e1 : e2;
    m_big   = swap ? m2 : m1;
    m_small = swap ? m1 : m2;
    e_diff  = e_big - e_small;

    special    = 1'b1;
    spec_out   = '0;
    spec_flags = '0;
    if (cls1 == CLS_NAN || cls2 == CLS_NAN ||
        (cls1 == CLS_INF && cls2 == CLS_INF && s1 != s2)) begin
      spec_out   = QNAN;
      spec_flags = F_INVALID;
    end else if (cls1 == CLS_INF) begin
      spec_out = a_r;
    end else if (cls2 == CLS_INF) begin
      spec_out = {s2, e2, m2};
    end else if (cls1 == CLS_ZERO && cls2 == CLS_ZERO) begin
      spec_out = {s1 & s2, {(W-1){1'b0}}};
    end else if (cls1 == CLS_ZERO) begin
      spec_out = {s2, e2, m2};
    end else if (cls2 == CLS_ZERO) begin
      spec_out = a_r;
    end else begin
      special = 1'b0;
    end
  end

  fp_align_shifter #(.WIDTH(SW), .SHW(EXP_W)) u_align (
    .value   ({1'b1, m_small, 3'b000}),
    .amount  (e_diff),
    .shifted (sigb_aligned)
  );

  logic [SW:0]      sum;
  logic             sum_zero, hidden, norm_uflow;
  logic             guard, round_bit, sticky, round_up, rnd_ovf;
  logic [MAN_W+1:0] mant_rnd;
  logic [MAN_W-1:0] mant_field;
  logic [EXP_W:0]   exp_rnd;

  always_comb begin
    sum        = eff_sub_r ? ({1'b0, sig_r} - {1'b0, sigb_r}) : ({1'b0, sig_r} + {1'b0, sigb_r});
    sum_zero   = (sum == '0);
    hidden     = sig_r[SW-1];
    norm_uflow = !hidden && (exp_r == (EXP_W+1)'(1));
    guard      = sig_r[2];
    round_bit  = sig_r[1];
    sticky     = sig_r[0];
    round_up   = guard & (round_bit | sticky | sig_r[3]);
    mant_rnd   = {1'b0, sig_r[SW-1:3]} + (MAN_W+2)'(round_up);
    // A round-up carry renormalises by one place, which leaves an all-zero mantissa.
    mant_field = mant_rnd[MAN_W+1] ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];
    exp_rnd    = exp_r + (EXP_W+1)'(mant_rnd[MAN_W+1]);
    rnd_ovf    = exp_rnd >= EXP_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (in_valid) next_state = S_ALIGN;
      S_ALIGN: next_state = special ? S_DONE : S_ADD;
      S_ADD:   next_state = sum_zero ? S_DONE : S_NORM;
      S_NORM: begin
        if (hidden)          next_state = S_ROUND;
        else if (norm_uflow) next_state = S_DONE;
      end
      S_ROUND: next_state = S_DONE;
      S_DONE:  if (out_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    out       = out_r;
    flags     = flags_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= 1'b0;
      sign_r    <= 1'b0;
      eff_sub_r <= 1'b0;
      exp_r     <= '0;
      sig_r     <= '0;
      sigb_r    <= '0;
      out_r     <= '0;
      flags_r   <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          a_r  <= in1;
          b_r  <= in2;
          op_r <= op;
        end
        S_ALIGN: begin
          if (special) begin
            out_r   <= spec_out;
            flags_r <= spec_flags;
          end else begin
            sign_r    <= s_big;
            eff_sub_r <= s1 ^ s2;
            exp_r     <= {1'b0, e_big};
            sig_r     <= {1'b1, m_big, 3'b000};
            sigb_r    <= sigb_aligned;
          end
        end
        S_ADD: begin
          if (sum_zero) begin
            out_r   <= '0;
            flags_r <= '0;
          end else if (sum[SW]) begin
            sig_r <= {sum[SW:2], sum[1] | sum[0]};
            exp_r <= exp_r + (EXP_W+1)'(1);
          end else begin
            sig_r <= sum[SW-1:0];
          end
        end
        S_NORM: if (!hidden) begin
          if (norm_uflow) begin
            out_r   <= {sign_r, {(W-1){1'b0}}};
            flags_r <= F_UFLOW | F_INEXACT;
          end else begin
            sig_r <= sig_r << 1;
            exp_r <= exp_r - (EXP_W+1)'(1);
          end
        end
        S_ROUND: begin
          if (rnd_ovf) begin
            out_r   <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_r <= F_OVFL | F_INEXACT;
          end else begin
            out_r   <= {sign_r, exp_rnd[EXP_W-1:0], mant_field};
            flags_r <= (guard | round_bit | sticky) ? F_INEXACT : 4'b0000;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
